// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side stream adapter.
package fifo_pkg;

    localparam int unsigned DEFAULT_DWIDTH = 8;

    // Encoding equals the number of buffered words.
    typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2} occ_state_t;

    typedef logic [DEFAULT_DWIDTH-1:0] word_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry head/skid storage with its occupancy FSM; head is the output word.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = DEFAULT_DWIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output occ_state_t        occ,
    output logic              valid,
    output logic [DWIDTH-1:0] head
);

    occ_state_t        occ_q, occ_d;
    logic [DWIDTH-1:0] head_q, head_d;
    logic [DWIDTH-1:0] skid_q, skid_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            occ_q  <= S0;
            head_q <= '0;
            skid_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            skid_q <= skid_d;
        end
    end

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;
        if (flush) begin
            // Returning word is dropped along with everything buffered.
            occ_d = S0;
        end else begin
            unique case (occ_q)
                S0: begin
                    if (push) begin
                        head_d = push_data;
                        occ_d  = S1;
                    end
                end
                S1: begin
                    if (push && pop) begin
                        head_d = push_data;
                    end else if (push) begin
                        skid_d = push_data;
                        occ_d  = S2;
                    end else if (pop) begin
                        occ_d = S0;
                    end
                end
                S2: begin
                    if (pop) begin
                        head_d = skid_q;
                        if (push) begin
                            skid_d = push_data;
                        end else begin
                            occ_d = S1;
                        end
                    end
                end
                default: occ_d = S0;
            endcase
        end
    end

    assign occ   = occ_q;
    assign valid = (occ_q != S0);
    assign head  = head_q;

endmodule

// File: rtl/fifo_stream_drain.sv
// Read-side adapter: turns the FIFO empty/r_en/dout interface into a valid/ready stream,
// hiding the one-cycle read latency behind a two-entry skid buffer.
module fifo_stream_drain
    import fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = DEFAULT_DWIDTH,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_dout,
    output logic              fifo_r_en,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic [CNT_W-1:0]  beat_count
);

    occ_state_t       occ;
    logic             pop;
    logic             inflight_q;
    logic [2:0]       load;
    logic [CNT_W-1:0] beat_q;

    assign pop  = m_valid && m_ready;
    // Words that will occupy the buffer after this edge; pop implies occ != 0.
    assign load = 3'(occ) + 3'(inflight_q) - 3'(pop);

    assign fifo_r_en = reset && !fifo_empty && !flush && (load < 3'd2);

    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight_q <= 1'b0;
            beat_q     <= '0;
        end else begin
            inflight_q <= fifo_r_en;
            if (pop) begin
                beat_q <= beat_q + CNT_W'(1);
            end
        end
    end

    skid_buf2 #(
        .DWIDTH(DWIDTH)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .push     (inflight_q),
        .push_data(fifo_dout),
        .pop      (pop),
        .occ      (occ),
        .valid    (m_valid),
        .head     (m_data)
    );

    assign beat_count = beat_q;

endmodule
